// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
//   Boot-time program loader in front of SingleCycleCPU. Bytes arrive over a
//   valid/ready stream and are packed little-endian into 32-bit words. Each
//   word is written to consecutive IMEM word addresses. The CPU is held in
//   reset until the image is complete. When the CPU halts, the loader flags
//   done, and it can be re-armed for a new image without a global reset.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   s_valid      byte offered on s_data
//   s_data       program byte
//   s_last       marks the final byte of the image
//   s_ready      loader accepts a byte this cycle
//   imem_we      IMEM write strobe, one cycle per word
//   imem_addr    IMEM byte address (word index * 4)
//   imem_wdata   assembled instruction word
//   cpu_rst      active-low CPU reset; low holds the CPU in reset
//   cpu_halt     CPU halt indication
//   reload       single-cycle request to reload; honoured only when halted
//   done         CPU has halted since it was last released
//   err_overflow image exceeded IMEM depth (sticky until rst)
//   word_count   words written for the current image (saturates at depth)
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  input  logic                  cpu_halt,
  input  logic                  reload,
  output logic                  done,
  output logic                  err_overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic                  s_ready_q, s_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [31:0]           imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_overflow_q, err_overflow_d;

  // Combinational helpers
  logic                  accept;
  logic                  word_done;
  logic                  room;
  logic [31:0]           merged;

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shreg_d        = shreg_q;
    word_idx_d     = word_idx_q;
    s_ready_d      = s_ready_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    cpu_rst_d      = cpu_rst_q;
    done_d         = done_q;
    err_overflow_d = err_overflow_q;

    accept    = 1'b0;
    word_done = 1'b0;
    // The word index never exceeds the depth, so its MSB alone says "full".
    room      = ~word_idx_q[ADDR_WIDTH];
    merged    = shreg_q | (32'(s_data) << {byte_idx_q, 3'b000});

    unique case (state_q)
      LOAD: begin
        accept = s_valid & s_ready_q;
        if (accept) begin
          word_done = (byte_idx_q == 2'd3) | s_last;
          if (word_done) begin
            byte_idx_d = '0;
            shreg_d    = '0;
            if (room) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = 32'(word_idx_q[ADDR_WIDTH-1:0]) << 2;
              imem_wdata_d = merged;
              word_idx_d   = word_idx_q + (ADDR_WIDTH+1)'(1);
            end else begin
              err_overflow_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = merged;
          end
          // Uses the updated overflow flag so an overflow on the final
          // word itself still routes to FAULT.
          if (s_last) begin
            s_ready_d = 1'b0;
            state_d   = err_overflow_d ? FAULT : RUN;
          end
        end
      end

      RUN: begin
        // cpu_rst rises one edge after entering RUN, so the final IMEM
        // write lands before the CPU's first fetch.
        cpu_rst_d = 1'b1;
        s_ready_d = 1'b0;
        if (cpu_halt) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end
      end

      HALTED: begin
        if (reload) begin
          state_d    = LOAD;
          cpu_rst_d  = 1'b0;
          done_d     = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          shreg_d    = '0;
          s_ready_d  = 1'b1;
        end
      end

      FAULT: begin
        s_ready_d = 1'b0;
        cpu_rst_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LOAD;
      byte_idx_q     <= '0;
      shreg_q        <= '0;
      word_idx_q     <= '0;
      s_ready_q      <= 1'b1;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_rst_q      <= 1'b0;
      done_q         <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shreg_q        <= shreg_d;
      word_idx_q     <= word_idx_d;
      s_ready_q      <= s_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_rst_q      <= cpu_rst_d;
      done_q         <= done_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign word_count   = word_idx_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Testbench for imem_loader: dut_a uses the default depth, dut_b a 4-word
// IMEM for the overflow path. Expected writes come from a packing model.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        s_valid, s_last, cpu_halt, reload;
  logic [7:0]  s_data;

  logic        s_ready_a, imem_we_a, cpu_rst_a, done_a, err_a;
  logic [31:0] imem_addr_a, imem_wdata_a;
  logic [10:0] word_count_a;

  logic        s_ready_b, imem_we_b, cpu_rst_b, done_b, err_b;
  logic [31:0] imem_addr_b, imem_wdata_b;
  logic [2:0]  word_count_b;

  imem_loader #(.ADDR_WIDTH(10)) dut_a (
    .clk(clk), .rst(rst_a), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_a), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .cpu_rst(cpu_rst_a), .cpu_halt(cpu_halt),
    .reload(reload), .done(done_a), .err_overflow(err_a), .word_count(word_count_a)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .cpu_rst(cpu_rst_b), .cpu_halt(cpu_halt),
    .reload(reload), .done(done_b), .err_overflow(err_b), .word_count(word_count_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  int          wc_a[$];
  int          rise_a = -1;
  logic        prev_a = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we_a === 1'b1) begin
      wq_a.push_back({imem_addr_a, imem_wdata_a});
      wc_a.push_back(cyc);
    end
    if (imem_we_b === 1'b1) wq_b.push_back({imem_addr_b, imem_wdata_b});
    if (cpu_rst_a === 1'b1 && prev_a === 1'b0) rise_a = cyc;
    prev_a = cpu_rst_a;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: chop the stream into 4-byte little-endian words, zero-pad the
  // tail, keep only words that fit in the IMEM.
  task automatic model(input logic [7:0] b[$], input int depth,
                       output logic [63:0] exp[$], output bit ovf, output int wcnt);
    int n;
    int nw;
    logic [31:0] word;
    n  = b.size();
    nw = (n + 3) / 4;
    exp = {};
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < n) word[8*k +: 8] = b[4*w + k];
      if (w < depth) exp.push_back({32'(w*4), word});
    end
    ovf  = (nw > depth);
    wcnt = (nw > depth) ? depth : nw;
  endtask

  // mode: 0 valid held, 1 valid toggles 1-0-1-0, 2 random valid
  task automatic send_image(input logic [7:0] b[$], input int mode, input bit with_last,
                            input bit use_b, output int cycles);
    int   i;
    int   n;
    bit   ph;
    logic v;
    logic rdy;
    i = 0; n = b.size(); ph = 1'b0; cycles = 0;
    while (i < n && cycles < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ~ph;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph      = ~ph;
      s_valid = v;
      s_data  = b[i];
      s_last  = with_last && (i == n - 1);
      rdy     = use_b ? s_ready_b : s_ready_a;
      @(posedge clk); #1;
      if (v && rdy) i++;
      cycles++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    tests++;
    if (i != n) begin
      fails++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic rearm();
    cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;
    reload   = 1'b1; @(posedge clk); #1; reload   = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; cpu_halt = 1'b0; reload = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests++; if (s_ready_a !== 1'b1)  begin fails++; $display("FAIL reset_s_ready: got %b expected 1", s_ready_a); end
    tests++; if (imem_we_a !== 1'b0)  begin fails++; $display("FAIL reset_we: got %b expected 0", imem_we_a); end
    tests++; if (imem_addr_a !== '0)  begin fails++; $display("FAIL reset_addr: got %h expected 0", imem_addr_a); end
    tests++; if (imem_wdata_a !== '0) begin fails++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata_a); end
    tests++; if (cpu_rst_a !== 1'b0)  begin fails++; $display("FAIL reset_cpu_rst: got %b expected 0", cpu_rst_a); end
    tests++; if (done_a !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b expected 0", done_a); end
    tests++; if (err_a !== 1'b0)      begin fails++; $display("FAIL reset_err: got %b expected 0", err_a); end
    tests++; if (word_count_a !== '0) begin fails++; $display("FAIL reset_wcount: got %0d expected 0", word_count_a); end
    rst_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00,
          8'h73, 8'h00, 8'h10, 8'h00};
    model(b, 1024, exp, ovf, wcnt);
    wq_a = {}; wc_a = {}; rise_a = -1;
    send_image(b, 0, 1'b1, 1'b0, used);
    repeat (3) @(posedge clk); #1;
    tests++; if (used != 12) begin fails++; $display("FAIL basic_cycles: took %0d cycles expected 12", used); end
    tests++; if (wq_a.size() != exp.size()) begin fails++; $display("FAIL basic_nwrites: got %0d expected %0d", wq_a.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < wq_a.size(); i++) begin
      tests++;
      if (wq_a[i] !== exp[i]) begin fails++; $display("FAIL basic_write%0d: got %h expected %h", i, wq_a[i], exp[i]); end
    end
    for (int i = 1; i < wc_a.size(); i++) begin
      tests++;
      if (wc_a[i] != wc_a[i-1] + 4) begin fails++; $display("FAIL basic_spacing%0d: got %0d expected %0d", i, wc_a[i], wc_a[i-1] + 4); end
    end
    if (wc_a.size() > 0) begin
      tests++;
      if (rise_a != wc_a[wc_a.size()-1] + 1) begin fails++; $display("FAIL basic_cpu_rst_rise: cycle %0d expected %0d", rise_a, wc_a[wc_a.size()-1] + 1); end
    end
    tests++; if (word_count_a !== 11'(wcnt)) begin fails++; $display("FAIL basic_wcount: got %0d expected %0d", word_count_a, wcnt); end
    tests++; if (s_ready_a !== 1'b0) begin fails++; $display("FAIL basic_s_ready: got %b expected 0", s_ready_a); end
    tests++; if (cpu_rst_a !== 1'b1) begin fails++; $display("FAIL basic_cpu_rst: got %b expected 1", cpu_rst_a); end
  endtask

  task automatic test_halt_reload();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    tests++; if (cpu_rst_a !== 1'b1)  begin fails++; $display("FAIL run_reload_cpu_rst: got %b expected 1", cpu_rst_a); end
    tests++; if (s_ready_a !== 1'b0)  begin fails++; $display("FAIL run_reload_s_ready: got %b expected 0", s_ready_a); end
    tests++; if (word_count_a !== 11'd3) begin fails++; $display("FAIL run_reload_wcount: got %0d expected 3", word_count_a); end
    cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;
    tests++; if (done_a !== 1'b1)     begin fails++; $display("FAIL halt_done: got %b expected 1", done_a); end
    tests++; if (cpu_rst_a !== 1'b1)  begin fails++; $display("FAIL halt_cpu_rst: got %b expected 1", cpu_rst_a); end
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    tests++; if (cpu_rst_a !== 1'b0)  begin fails++; $display("FAIL reload_cpu_rst: got %b expected 0", cpu_rst_a); end
    tests++; if (done_a !== 1'b0)     begin fails++; $display("FAIL reload_done: got %b expected 0", done_a); end
    tests++; if (word_count_a !== '0) begin fails++; $display("FAIL reload_wcount: got %0d expected 0", word_count_a); end
    tests++; if (s_ready_a !== 1'b1)  begin fails++; $display("FAIL reload_s_ready: got %b expected 1", s_ready_a); end
    cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;
    tests++; if (done_a !== 1'b0)     begin fails++; $display("FAIL load_halt_done: got %b expected 0", done_a); end
    b = {};
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model(b, 1024, exp, ovf, wcnt);
    wq_a = {};
    send_image(b, 0, 1'b1, 1'b0, used);
    repeat (2) @(posedge clk); #1;
    tests++; if (wq_a.size() != 1) begin fails++; $display("FAIL reimage_nwrites: got %0d expected 1", wq_a.size()); end
    if (wq_a.size() > 0) begin
      tests++;
      if (wq_a[0] !== exp[0]) begin fails++; $display("FAIL reimage_write: got %h expected %h", wq_a[0], exp[0]); end
    end
  endtask

  task automatic test_padding();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    rearm();
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    model(b, 1024, exp, ovf, wcnt);
    wq_a = {};
    send_image(b, 0, 1'b1, 1'b0, used);
    tests++; if (s_ready_a !== 1'b0) begin fails++; $display("FAIL pad_s_ready: got %b expected 0", s_ready_a); end
    repeat (2) @(posedge clk); #1;
    tests++; if (wq_a.size() != exp.size()) begin fails++; $display("FAIL pad_nwrites: got %0d expected %0d", wq_a.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < wq_a.size(); i++) begin
      tests++;
      if (wq_a[i] !== exp[i]) begin fails++; $display("FAIL pad_write%0d: got %h expected %h", i, wq_a[i], exp[i]); end
    end
    tests++; if (cpu_rst_a !== 1'b1) begin fails++; $display("FAIL pad_run: cpu_rst got %b expected 1", cpu_rst_a); end
  endtask

  task automatic test_valid_toggle();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    rearm();
    b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00,
          8'h73, 8'h00, 8'h10, 8'h00};
    model(b, 1024, exp, ovf, wcnt);
    wq_a = {};
    send_image(b, 1, 1'b1, 1'b0, used);
    repeat (4) @(posedge clk); #1;
    tests++; if (used != 23) begin fails++; $display("FAIL toggle_cycles: took %0d expected 23", used); end
    tests++; if (wq_a.size() != exp.size()) begin fails++; $display("FAIL toggle_nwrites: got %0d expected %0d", wq_a.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < wq_a.size(); i++) begin
      tests++;
      if (wq_a[i] !== exp[i]) begin fails++; $display("FAIL toggle_write%0d: got %h expected %h", i, wq_a[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used, n;
    for (int r = 0; r < 6; r++) begin
      rearm();
      n = int'($urandom_range(1, 40));
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      model(b, 1024, exp, ovf, wcnt);
      wq_a = {};
      send_image(b, 2, 1'b1, 1'b0, used);
      repeat (3) @(posedge clk); #1;
      tests++; if (wq_a.size() != exp.size()) begin fails++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", r, wq_a.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < wq_a.size(); i++) begin
        tests++;
        if (wq_a[i] !== exp[i]) begin fails++; $display("FAIL rand%0d_write%0d: got %h expected %h", r, i, wq_a[i], exp[i]); end
      end
      tests++; if (word_count_a !== 11'(wcnt)) begin fails++; $display("FAIL rand%0d_wcount: got %0d expected %0d", r, word_count_a, wcnt); end
      tests++; if (cpu_rst_a !== 1'b1) begin fails++; $display("FAIL rand%0d_cpu_rst: got %b expected 1", r, cpu_rst_a); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    rearm();
    b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00};
    send_image(b, 0, 1'b0, 1'b0, used);
    rst_a = 1'b0; #1;
    tests++; if (word_count_a !== '0) begin fails++; $display("FAIL midrst_wcount: got %0d expected 0", word_count_a); end
    @(posedge clk); #1; rst_a = 1'b1;
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    model(b, 1024, exp, ovf, wcnt);
    wq_a = {};
    send_image(b, 0, 1'b1, 1'b0, used);
    repeat (2) @(posedge clk); #1;
    tests++; if (wq_a.size() != 2) begin fails++; $display("FAIL midrst_nwrites: got %0d expected 2", wq_a.size()); end
    for (int i = 0; i < exp.size() && i < wq_a.size(); i++) begin
      tests++;
      if (wq_a[i] !== exp[i]) begin fails++; $display("FAIL midrst_write%0d: got %h expected %h", i, wq_a[i], exp[i]); end
    end
    // Reset landing on the write cycle must kill the strobe immediately
    rearm();
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_image(b, 0, 1'b0, 1'b0, used);
    tests++; if (imem_we_a !== 1'b1) begin fails++; $display("FAIL inflight_we_pre: got %b expected 1", imem_we_a); end
    rst_a = 1'b0; #1;
    tests++; if (imem_we_a !== 1'b0) begin fails++; $display("FAIL inflight_we_cleared: got %b expected 0", imem_we_a); end
    @(posedge clk); #1; rst_a = 1'b1;
  endtask

  task automatic test_overflow();
    logic [7:0]  b[$];
    logic [63:0] exp[$];
    bit          ovf;
    int          wcnt, used;
    rst_b = 1'b1;
    @(posedge clk); #1;
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    model(b, 4, exp, ovf, wcnt);
    wq_b = {};
    send_image(b, 0, 1'b1, 1'b1, used);
    repeat (3) @(posedge clk); #1;
    tests++; if (used != 20) begin fails++; $display("FAIL ovf_cycles: took %0d expected 20", used); end
    tests++; if (wq_b.size() != exp.size()) begin fails++; $display("FAIL ovf_nwrites: got %0d expected %0d", wq_b.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < wq_b.size(); i++) begin
      tests++;
      if (wq_b[i] !== exp[i]) begin fails++; $display("FAIL ovf_write%0d: got %h expected %h", i, wq_b[i], exp[i]); end
    end
    tests++; if (err_b !== 1'(ovf)) begin fails++; $display("FAIL ovf_flag: got %b expected %b", err_b, ovf); end
    tests++; if (word_count_b !== 3'(wcnt)) begin fails++; $display("FAIL ovf_wcount: got %0d expected %0d", word_count_b, wcnt); end
    tests++; if (s_ready_b !== 1'b0) begin fails++; $display("FAIL ovf_s_ready: got %b expected 0", s_ready_b); end
    tests++; if (cpu_rst_b !== 1'b0) begin fails++; $display("FAIL ovf_cpu_rst: got %b expected 0", cpu_rst_b); end
    rearm();
    repeat (2) @(posedge clk); #1;
    tests++; if (s_ready_b !== 1'b0 || cpu_rst_b !== 1'b0 || err_b !== 1'b1 || done_b !== 1'b0) begin
      fails++;
      $display("FAIL fault_sticky: s_ready=%b cpu_rst=%b err=%b done=%b expected 0 0 1 0", s_ready_b, cpu_rst_b, err_b, done_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt_reload();
    test_padding();
    test_valid_toggle();
    test_random();
    test_mid_reset();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
